stream_rr_arbiter: RTL and testbench

//  Two-requester arbiter that merges the in1/in2 valid/ready streams (payload {data, data2}) onto one out stream.

---
 rtl/stream_pkg.sv | 18 +
 rtl/stream_rr_arbiter_if.sv | 25 ++
 rtl/stream_out_reg.sv | 38 +++
 rtl/stream_rr_arbiter.sv | 97 +++++++++
 tb/tb_stream_rr_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared types for the two-requester stream arbiter.
// Payload layout and source encoding used by every stage.
package stream_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int DATA2_WIDTH = 13;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]         data;
        logic signed [DATA2_WIDTH-1:0] data2;
    } stream_payload_t;

    typedef enum logic {
        SRC_IN1,
        SRC_IN2
    } stream_src_e;

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Valid/ready stream carrying one {data, data2} payload.
// master drives payload and valid; slave drives ready.
interface stream_rr_arbiter_if;
    import stream_pkg::*;

    logic [DATA_WIDTH-1:0]         data;
    logic signed [DATA2_WIDTH-1:0] data2;
    logic                          valid;
    logic                          ready;

    modport master (
        output data,
        output data2,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  data2,
        input  valid,
        output ready
    );

endinterface

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register holding payload and source.
// Accepts a new beat whenever empty or being drained this cycle.
module stream_out_reg
    import stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  stream_payload_t       payload,
    input  stream_src_e           src,
    output logic                  load,
    output stream_src_e           out_src,
    stream_rr_arbiter_if.master   out
);

    stream_payload_t q;
    logic            vld;

    assign load      = !vld | out.ready;
    assign out.valid = vld;
    assign out.data  = q.data;
    assign out.data2 = q.data2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld     <= 1'b0;
            q       <= '0;
            out_src <= SRC_IN1;
        end else if (load) begin
            vld <= push;
            if (push) begin
                q       <= payload;
                out_src <= src;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of two streams with a per-owner burst limit.
// Grant state lives here; the output beat is held in stream_out_reg.
module stream_rr_arbiter
    import stream_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_rr_arbiter_if.slave  in1,
    stream_rr_arbiter_if.slave  in2,
    stream_rr_arbiter_if.master out,
    output logic                out_src
);

    localparam int CW = $clog2(MAX_BURST + 1);

    stream_src_e     last_grant, last_grant_n;
    logic [CW-1:0]   burst_cnt, burst_cnt_n;
    stream_src_e     winner, src_q;
    stream_payload_t payload;
    logic            grant;
    logic            load;
    logic            push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_IN1;
            burst_cnt  <= '0;
        end else begin
            last_grant <= last_grant_n;
            burst_cnt  <= burst_cnt_n;
        end
    end

    always_comb begin
        grant        = 1'b0;
        winner       = SRC_IN1;
        payload      = '0;
        last_grant_n = last_grant;
        burst_cnt_n  = burst_cnt;

        unique case (1'b1)
            in1.valid && in2.valid: begin
                grant = 1'b1;
                // owner keeps the port until its burst budget is spent
                if (burst_cnt < CW'(MAX_BURST))
                    winner = last_grant;
                else
                    winner = (last_grant == SRC_IN1) ? SRC_IN2 : SRC_IN1;
            end
            in1.valid && !in2.valid: begin
                grant  = 1'b1;
                winner = SRC_IN1;
            end
            !in1.valid && in2.valid: begin
                grant  = 1'b1;
                winner = SRC_IN2;
            end
            default: ;
        endcase

        if (winner == SRC_IN2) begin
            payload.data  = in2.data;
            payload.data2 = in2.data2;
        end else begin
            payload.data  = in1.data;
            payload.data2 = in1.data2;
        end

        in1.ready = rst_n & load & grant & (winner == SRC_IN1);
        in2.ready = rst_n & load & grant & (winner == SRC_IN2);
        push      = in1.ready | in2.ready;

        if (push) begin
            last_grant_n = winner;
            if (winner != last_grant)
                burst_cnt_n = CW'(1);
            else if (burst_cnt != CW'(MAX_BURST))
                burst_cnt_n = burst_cnt + 1'b1;
        end
    end

    stream_out_reg u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .payload (payload),
        .src     (winner),
        .load    (load),
        .out_src (src_q),
        .out     (out)
    );

    assign out_src = src_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter with an in-order scoreboard.
// A second instance is built with MAX_BURST=1 for alternation.
module tb_stream_rr_arbiter;
    import stream_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic src, src_b;

    always #5 clk = ~clk;

    stream_rr_arbiter_if i1 ();
    stream_rr_arbiter_if i2 ();
    stream_rr_arbiter_if o ();
    stream_rr_arbiter_if b1 ();
    stream_rr_arbiter_if b2 ();
    stream_rr_arbiter_if bo ();

    stream_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in1     (i1),
        .in2     (i2),
        .out     (o),
        .out_src (src)
    );

    stream_rr_arbiter #(.MAX_BURST(1)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .in1     (b1),
        .in2     (b2),
        .out     (bo),
        .out_src (src_b)
    );

    typedef struct {
        logic [15:0] d;
        logic [12:0] d2;
        logic        s;
    } beat_t;

    beat_t sb[$];
    beat_t e;
    logic  src_log[$];
    int    checks = 0;
    int    errors = 0;
    int    n1 = 0;
    int    n2 = 0;
    logic  r1, r2;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pop before push: the beat on out was accepted in an earlier cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (o.valid && o.ready) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_data", 32'(o.data), 32'(e.d));
                    chk("sb_data2", {19'b0, o.data2}, {19'b0, e.d2});
                    chk("sb_src", 32'(src), 32'(e.s));
                    src_log.push_back(src);
                end
            end
            if (i1.valid && i1.ready)
                sb.push_back('{i1.data, i1.data2, 1'b0});
            if (i2.valid && i2.ready)
                sb.push_back('{i2.data, i2.data2, 1'b1});
        end
    end

    task automatic cyc(input logic v1, input logic v2, input logic rdy);
        i1.valid = v1;
        i1.data  = 16'h1000 + 16'(n1);
        i1.data2 = 13'(n1 * 3 - 50);
        i2.valid = v2;
        i2.data  = 16'h2000 + 16'(n2);
        i2.data2 = 13'(-(n2 + 1));
        o.ready  = rdy;
        @(negedge clk);
        r1 = i1.ready;
        r2 = i2.ready;
        @(posedge clk);
        #1;
        if (r1) n1++;
        if (r2) n2++;
    endtask

    initial begin
        logic [12:0] e2;
        int          n2_before;

        i1.valid = 1'b1; i1.data = '0; i1.data2 = '0;
        i2.valid = 1'b1; i2.data = '0; i2.data2 = '0;
        b1.valid = 1'b0; b1.data = '0; b1.data2 = '0;
        b2.valid = 1'b0; b2.data = '0; b2.data2 = '0;
        o.ready  = 1'b0;
        bo.ready = 1'b0;

        // reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(o.valid), 32'd0);
        chk("rst_data", 32'(o.data), 32'd0);
        chk("rst_data2", {19'b0, o.data2}, 32'd0);
        chk("rst_src", 32'(src), 32'd0);
        chk("rst_rdy1", 32'(i1.ready), 32'd0);
        chk("rst_rdy2", 32'(i2.ready), 32'd0);
        i1.valid = 1'b0;
        i2.valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single source, 1-cycle latency, no bubbles
        for (int i = 1; i <= 8; i++) begin
            i1.valid = 1'b1;
            i1.data  = 16'(i);
            i1.data2 = 13'(-i);
            o.ready  = 1'b1;
            e2       = 13'(-i);
            @(negedge clk);
            chk("t2_rdy", 32'(i1.ready), 32'd1);
            @(posedge clk);
            #1;
            chk("t2_valid", 32'(o.valid), 32'd1);
            chk("t2_data", 32'(o.data), 32'(i));
            chk("t2_data2", {19'b0, o.data2}, {19'b0, e2});
            chk("t2_src", 32'(src), 32'd0);
        end
        i1.valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);

        // reset while a beat is held
        i1.valid = 1'b1;
        i1.data  = 16'h0055;
        o.ready  = 1'b0;
        @(posedge clk);
        #1;
        chk("t1_held", 32'(o.valid), 32'd1);
        i2.valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        sb.delete();
        chk("t1_valid", 32'(o.valid), 32'd0);
        chk("t1_rdy1", 32'(i1.ready), 32'd0);
        chk("t1_rdy2", 32'(i2.ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        i1.valid = 1'b0;
        i2.valid = 1'b0;

        // contention with MAX_BURST=4
        src_log.delete();
        n1 = 0;
        n2 = 0;
        for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t3_count", 32'(src_log.size()), 32'd16);
        for (int k = 0; k < 16; k++)
            if (k < src_log.size())
                chk("t3_src", 32'(src_log[k]), 32'((k / 4) % 2));
        chk("t3_n1", 32'(n1), 32'd8);
        chk("t3_n2", 32'(n2), 32'd8);

        // backpressure: in2 waits while in1's beat is stalled
        src_log.delete();
        i1.valid = 1'b1; i1.data = 16'h00A1; i1.data2 = 13'h0AA;
        i2.valid = 1'b1; i2.data = 16'h00B1; i2.data2 = 13'h1BB;
        o.ready  = 1'b1;
        @(negedge clk);
        chk("t4_rdy1", 32'(i1.ready), 32'd1);
        chk("t4_rdy2", 32'(i2.ready), 32'd0);
        @(posedge clk);
        #1;
        i1.valid = 1'b0;
        o.ready  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_stall_rdy1", 32'(i1.ready), 32'd0);
            chk("t4_stall_rdy2", 32'(i2.ready), 32'd0);
            chk("t4_stall_valid", 32'(o.valid), 32'd1);
            chk("t4_stall_data", 32'(o.data), 32'h00A1);
            chk("t4_stall_data2", {19'b0, o.data2}, 32'h0AA);
            chk("t4_stall_src", 32'(src), 32'd0);
            @(posedge clk);
            #1;
        end
        o.ready = 1'b1;
        @(negedge clk);
        chk("t4_resume_rdy2", 32'(i2.ready), 32'd1);
        @(posedge clk);
        #1;
        i2.valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        chk("t4_count", 32'(src_log.size()), 32'd2);
        if (src_log.size() == 2) begin
            chk("t4_src0", 32'(src_log[0]), 32'd0);
            chk("t4_src1", 32'(src_log[1]), 32'd1);
        end

        // owner drops valid mid-burst
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        src_log.delete();
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        n2_before = n2;
        cyc(1'b0, 1'b1, 1'b1);
        chk("t5_takeover", 32'(n2 - n2_before), 32'd1);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t5_count", 32'(src_log.size()), 32'd7);
        for (int k = 0; k < 7; k++)
            if (k < src_log.size())
                chk("t5_src", 32'(src_log[k]), 32'((k >= 2 && k <= 5) ? 1 : 0));

        // boundary payloads
        i1.valid = 1'b1; i1.data = 16'hFFFF; i1.data2 = 13'h1000;
        o.ready  = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_data_max", 32'(o.data), 32'h0000FFFF);
        chk("t6_data2_min", {19'b0, o.data2}, 32'h00001000);
        i1.data = 16'h0000; i1.data2 = 13'h0FFF;
        @(posedge clk);
        #1;
        chk("t6_data_zero", 32'(o.data), 32'd0);
        chk("t6_data2_max", {19'b0, o.data2}, 32'h00000FFF);
        i1.valid = 1'b0;
        i2.valid = 1'b1; i2.data = 16'hFFFF; i2.data2 = 13'h1000;
        @(posedge clk);
        #1;
        chk("t6_in2_src", 32'(src), 32'd1);
        chk("t6_in2_data2", {19'b0, o.data2}, 32'h00001000);
        i2.valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);

        // MAX_BURST=1 alternates under contention
        b1.valid = 1'b1; b1.data = 16'h1111; b1.data2 = 13'h0011;
        b2.valid = 1'b1; b2.data = 16'h2222; b2.data2 = 13'h1022;
        bo.ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("t6_alt_valid", 32'(bo.valid), 32'd1);
            chk("t6_alt_src", 32'(src_b), 32'(k % 2));
            chk("t6_alt_data", 32'(bo.data),
                (k % 2) ? 32'h2222 : 32'h1111);
        end
        b1.valid = 1'b0;
        b2.valid = 1'b0;
        @(posedge clk);
        #1;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
